// File: rtl/if_prefetch.sv
// -----------------------------------------------------------------------------
// if_prefetch -- instruction-fetch stage with a DEPTH-entry prefetch queue.
//
// The stage owns the fetch PC. It issues one sequential request at a time to
// the Memory Controller and buffers the returned {pc, inst} pairs in a
// show-ahead FIFO, so decode only stalls when the queue is empty. MEM traffic
// keeps priority on the Memory Controller. An EX jump flushes the queue,
// redirects fetch and discards whatever response is still in flight.
//
// Ports:
//   clk_in           clock, rising edge
//   rst_in           asynchronous active-low reset
//   pcJump_in        EX jump/branch taken (pulse)
//   pcJumpAddr_in    jump target, valid with pcJump_in
//   stall_in         downstream cannot accept the queue head this cycle
//   MEM_MCAccess_in  MEM requests the Memory Controller this cycle
//   MC_busyIF_in     Memory Controller busy with an IF request
//   MC_busyMEM_in    Memory Controller busy with a MEM request
//   instE_in         instruction response valid (1-cycle pulse)
//   inst_in          response data
//   MCE_out          fetch request strobe
//   MCAddr_out       fetch request address
//   instE_out        queue head valid
//   pc_out           PC of the queue head
//   inst_out         instruction of the queue head
//   ifStall_out      queue empty
// -----------------------------------------------------------------------------
module if_prefetch #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              pcJump_in,
  input  logic [ADDR_W-1:0] pcJumpAddr_in,
  input  logic              stall_in,
  input  logic              MEM_MCAccess_in,
  input  logic              MC_busyIF_in,
  input  logic              MC_busyMEM_in,
  input  logic              instE_in,
  input  logic [INST_W-1:0] inst_in,
  output logic              MCE_out,
  output logic [ADDR_W-1:0] MCAddr_out,
  output logic              instE_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [INST_W-1:0] inst_out,
  output logic              ifStall_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  localparam logic [1:0] ST_IDLE    = 2'd0;  // no request outstanding
  localparam logic [1:0] ST_WAIT    = 2'd1;  // live request outstanding
  localparam logic [1:0] ST_DISCARD = 2'd2;  // outstanding request killed by a jump

  logic [1:0]        state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_pc;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    count;

  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [INST_W-1:0] q_inst [DEPTH];

  logic issue;
  logic push;
  logic pop;
  logic head_valid;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would infer a latch.
  always_comb begin
    issue = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    // rst_in gates the strobe so the request port stays quiet during reset.
    if (rst_in && state == ST_IDLE && !pcJump_in && !MEM_MCAccess_in &&
        !MC_busyMEM_in && !MC_busyIF_in && count < FULL)
      issue = 1'b1;
    if (state == ST_WAIT && instE_in && !pcJump_in)
      push = 1'b1;
    if (head_valid && !stall_in && !pcJump_in)
      pop = 1'b1;
  end

  assign head_valid  = (count != '0);
  assign MCE_out     = issue;
  assign MCAddr_out  = issue ? fetch_pc : '0;
  assign instE_out   = head_valid;
  assign pc_out      = head_valid ? q_pc[rd_ptr]   : '0;
  assign inst_out    = head_valid ? q_inst[rd_ptr] : '0;
  assign ifStall_out = !head_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (pcJump_in) begin
      // Jump wins over everything: flush, redirect, and track the in-flight
      // response so its data is never pushed.
      fetch_pc <= pcJumpAddr_in;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      // A response arriving with the jump is dropped and nothing is left in
      // flight, so both WAIT and DISCARD return to IDLE in that case.
      if (state == ST_WAIT || state == ST_DISCARD)
        state <= instE_in ? ST_IDLE : ST_DISCARD;
      else
        state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (issue) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
            state    <= ST_WAIT;
          end
        end
        ST_WAIT:    if (instE_in) state <= ST_IDLE;
        ST_DISCARD: if (instE_in) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: queue storage has no reset; count gates every read, so stale
  // contents are never visible and the array can map onto plain RAM/flops.
  always_ff @(posedge clk_in) begin
    if (push) begin
      q_pc[wr_ptr]   <= req_pc;
      q_inst[wr_ptr] <= inst_in;
    end
  end

endmodule

// File: doc/if_prefetch.md
Name: if_prefetch

Overview:
- Next-generation instruction-fetch stage: owns the fetch PC, issues sequential requests to the Memory Controller and buffers returned instructions in a DEPTH-entry prefetch queue.
- The queue decouples fetch from decode, so the stage no longer stalls the pipeline on every fetch.
- Sits between the PC/Memory Controller and IF_ID.
- MEM accesses keep priority on the Memory Controller.
- An EX jump flushes the queue, redirects fetch and discards any in-flight response.

Parameters:
- ADDR_W, 32, address/PC width.
- INST_W, 32, instruction width.
- DEPTH, 4, prefetch queue entries; power of two, at least 2.
- RESET_PC, 0, fetch PC after reset.
- PC_STEP, 4, sequential PC increment.

Ports:
- clk_in  in  1  clock; all state updates on the rising edge.
- rst_in  in  1  reset, asynchronous, active-low.
- pcJump_in  in  1  EX jump/branch taken (pulse).
- pcJumpAddr_in  in  ADDR_W  jump target; valid with pcJump_in.
- stall_in  in  1  downstream (IF_ID/ID) cannot accept this cycle.
- MEM_MCAccess_in  in  1  MEM requests the Memory Controller this cycle.
- MC_busyIF_in  in  1  Memory Controller is servicing an IF request.
- MC_busyMEM_in  in  1  Memory Controller is servicing a MEM request.
- instE_in  in  1  instruction response valid (1-cycle pulse).
- inst_in  in  INST_W  response data.
- MCE_out  out  1  fetch request strobe (1 cycle).
- MCAddr_out  out  ADDR_W  fetch request address.
- instE_out  out  1  queue head valid to IF_ID.
- pc_out  out  ADDR_W  PC of the queue head.
- inst_out  out  INST_W  instruction of the queue head.
- ifStall_out  out  1  stall request: queue empty.

Behaviour:
- Reset (asynchronous, rst_in=0):
  - fetch_pc=RESET_PC; queue count=0; read/write pointers=0; state=IDLE.
  - All outputs 0: MCE_out, MCAddr_out, instE_out, pc_out, inst_out.
  - ifStall_out=1 (queue empty).
  - Reset mid-request abandons the request; a late instE_in is ignored because state=IDLE.
- States:
  - IDLE: no request outstanding.
  - WAIT: one request outstanding; address held in req_pc.
  - DISCARD: the outstanding request was killed by a jump.
  - At most one request is outstanding at any time.
- Issue condition (IDLE only):
  - pcJump_in=0, MEM_MCAccess_in=0, MC_busyMEM_in=0, MC_busyIF_in=0, and count<DEPTH.
  - When met, in the same cycle (combinational): MCE_out=1, MCAddr_out=fetch_pc.
  - Next edge: req_pc<=fetch_pc; fetch_pc<=fetch_pc+PC_STEP, wrapping modulo 2^ADDR_W; state<=WAIT.
  - When not met: MCE_out=0, MCAddr_out=0.
- WAIT:
  - instE_in=1 and no jump: push {req_pc, inst_in}; state<=IDLE.
  - Queue space is guaranteed because issue required count<DEPTH.
- Jump (pcJump_in=1), has priority over every other event in the same cycle:
  - Flush queue: count<=0, pointers<=0.
  - fetch_pc<=pcJumpAddr_in; no request is issued that cycle.
  - WAIT with instE_in=1 the same cycle: response dropped; state<=IDLE.
  - WAIT without instE_in: state<=DISCARD.
  - DISCARD: stays DISCARD; fetch_pc is still updated.
  - A pop in the same cycle is cancelled by the flush.
- DISCARD: instE_in=1 -> drop the data; state<=IDLE.
- Queue output (show-ahead):
  - instE_out=(count!=0); pc_out/inst_out=head entry, else 0.
  - Pop when instE_out=1 and stall_in=0 and pcJump_in=0.
  - Push and pop in the same cycle: count unchanged; both pointers advance modulo DEPTH.
- ifStall_out=(count==0), combinational. It is not asserted merely because MEM holds the Memory Controller while the queue is non-empty.
- Latency:
  - Jump at edge N -> earliest request in cycle N+1.
  - Response at edge M -> head visible in cycle M+1.
- Full queue (count==DEPTH) blocks issue only. Outstanding responses always have space.

Test Plan:
- Reset, then Memory Controller responds 2 cycles after each MCE_out with inst=0xA0+index, stall_in=0 -> requests at 0x0, 0x4, 0x8; instE_out pulses with pc_out 0x0, 0x4, 0x8 in order; pc/inst pairs match.
- Hold stall_in=1 with DEPTH=4 -> exactly 4 requests (0x0..0xC); MCE_out stays 0; release stall -> entries drain in order and fetch resumes at 0x10.
- Jump to 0x100 while WAIT on 0x8 with response 1 cycle later -> that response is dropped; queue empty; next MCE_out has MCAddr_out=0x100; first instE_out has pc_out=0x100.
- Jump with instE_in in the same cycle and 2 entries queued -> count=0; response not pushed; next cycle instE_out=0; next request at the target.
- MEM_MCAccess_in=1 or MC_busyMEM_in=1 for 5 cycles with 2 entries queued -> no MCE_out; instE_out keeps delivering; ifStall_out=0 until empty, then 1.
- rst_in=0 mid-WAIT, release, late instE_in arrives -> ignored; first request at RESET_PC; all outputs 0 during reset.
